// File: rtl/neuron_lanes.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_lanes
//  Purpose  : One fully-connected neuron, out = sum(x[i]*w[i]) + bias, using
//             LANES parallel signed MACs. Inputs and weights are streamed one
//             beat (LANES elements) at a time. The result leaves on a
//             valid/ready output port.
//  Option   : NEURON_LANES_RELU_SAT_EN - widened final sum, then ReLU and
//             clamping to the largest positive WIDTH_OUT value.
//  Revision : 1.0  initial release
// ============================================================================
module neuron_lanes #(
    parameter int IN_SIZE    = 196,
    parameter int LANES      = 4,
    parameter int WIDTH_IN   = 8,
    parameter int WIDTH      = 8,
    parameter int BIAS_WIDTH = 8,
    parameter int WIDTH_OUT  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic signed [BIAS_WIDTH-1:0]  bias,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*WIDTH_IN-1:0]     in_data,
    input  logic [LANES*WIDTH-1:0]        weight,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [WIDTH_OUT-1:0]   out_data,
    output logic                          busy
);

    localparam int c_beats  = (IN_SIZE + LANES - 1) / LANES;
    localparam int c_cnt_w  = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int c_prod_w = WIDTH_IN + WIDTH;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(c_beats - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_REDUCE = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t                        r_state;
    logic [c_cnt_w-1:0]            r_beat_cnt;
    logic signed [BIAS_WIDTH-1:0]  r_bias;
    // Products of the accepted beat are registered before they reach the
    // accumulators, keeping the multiplier and the adder in separate cycles.
    logic                          r_prod_valid;
    logic signed [WIDTH_OUT-1:0]   r_prod [LANES];
    logic signed [WIDTH_OUT-1:0]   r_acc  [LANES];

    logic signed [WIDTH_IN-1:0]    w_x;
    logic signed [WIDTH-1:0]       w_w;
    logic signed [c_prod_w-1:0]    w_prod;
    logic                          w_lane_en;
    logic signed [WIDTH_OUT-1:0]   w_term [LANES];
    logic signed [WIDTH_OUT-1:0]   w_result;

    // Per-lane signed product, zeroed for element indices past IN_SIZE
    always_comb begin
        w_x       = '0;
        w_w       = '0;
        w_prod    = '0;
        w_lane_en = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            w_x       = in_data[k*WIDTH_IN +: WIDTH_IN];
            w_w       = weight[k*WIDTH +: WIDTH];
            w_prod    = c_prod_w'(w_x) * c_prod_w'(w_w);
            w_lane_en = ((32'(r_beat_cnt) * 32'(LANES)) + 32'(k)) < 32'(IN_SIZE);
            w_term[k] = w_lane_en ? WIDTH_OUT'(w_prod) : '0;
        end
    end

`ifdef NEURON_LANES_RELU_SAT_EN
    localparam int c_sum_w = WIDTH_OUT + $clog2(LANES + 1) + 1;
    localparam logic signed [c_sum_w-1:0] c_pos_max =
        c_sum_w'({1'b0, {(WIDTH_OUT-1){1'b1}}});

    logic signed [c_sum_w-1:0] w_sum_wide;

    // Wide reduction of the lane accumulators, then ReLU and positive clamp
    always_comb begin
        w_sum_wide = c_sum_w'(r_bias);
        for (int k = 0; k < LANES; k++) begin
            w_sum_wide = w_sum_wide + c_sum_w'(r_acc[k]);
        end
        if (w_sum_wide[c_sum_w-1]) begin
            w_result = '0;
        end else if (w_sum_wide > c_pos_max) begin
            w_result = c_pos_max[WIDTH_OUT-1:0];
        end else begin
            w_result = w_sum_wide[WIDTH_OUT-1:0];
        end
    end
`else
    // Wrapping reduction of the lane accumulators plus sign-extended bias
    always_comb begin
        w_result = WIDTH_OUT'(r_bias);
        for (int k = 0; k < LANES; k++) begin
            w_result = w_result + r_acc[k];
        end
    end
`endif

    // Control FSM with registered handshake outputs, accumulators and result
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_beat_cnt   <= '0;
            r_bias       <= '0;
            r_prod_valid <= 1'b0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            busy         <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                r_prod[k] <= '0;
                r_acc[k]  <= '0;
            end
        end else begin
            r_prod_valid <= 1'b0;
            if (r_prod_valid) begin
                for (int k = 0; k < LANES; k++) begin
                    r_acc[k] <= r_acc[k] + r_prod[k];
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bias     <= bias;
                        r_beat_cnt <= '0;
                        for (int k = 0; k < LANES; k++) begin
                            r_acc[k] <= '0;
                        end
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= S_ACCUM;
                    end
                end

                S_ACCUM: begin
                    // in_ready is high throughout this state
                    if (in_valid) begin
                        for (int k = 0; k < LANES; k++) begin
                            r_prod[k] <= w_term[k];
                        end
                        r_prod_valid <= 1'b1;
                        if (r_beat_cnt == c_last_beat) begin
                            in_ready <= 1'b0;
                            r_state  <= S_REDUCE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
                        end
                    end
                end

                S_REDUCE: begin
                    // Wait for the final beat's products to land in the
                    // accumulators, then register the reduced result.
                    if (!r_prod_valid) begin
                        out_data  <= w_result;
                        out_valid <= 1'b1;
                        r_state   <= S_OUTPUT;
                    end
                end

                S_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neuron_lanes.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neuron_lanes
//  Purpose  : Self-checking bench for neuron_lanes. A small instance
//             (IN_SIZE=6, LANES=4, WIDTH_OUT=16) is compared every cycle
//             against an element-level reference model; a default-parameter
//             instance runs the full-size saturation-free dot product.
//  Option   : NEURON_LANES_RELU_SAT_EN changes the expected results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_neuron_lanes;

    localparam int IN_A    = 6;
    localparam int LN      = 4;
    localparam int WO      = 16;
    localparam int BEATS_A = 2;
    localparam int BEATS_B = 49;

`ifdef NEURON_LANES_RELU_SAT_EN
    localparam longint EXP_NEG = 0;
    localparam longint EXP_BIG = 32767;
    localparam longint EXP_B   = 0;
`else
    localparam longint EXP_NEG = -50;
    localparam longint EXP_BIG = -25536;
    localparam longint EXP_B   = -3186304;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [7:0]  bias;
    logic        in_valid;
    logic [31:0] in_data, weight;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, busy_a;
    logic [WO-1:0] out_data_a;
    logic        in_ready_b, out_valid_b, busy_b;
    logic [31:0] out_data_b;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit junk_rand = 1'b0;
    int tx [IN_A];
    int tw [IN_A];

    always #5 clk = ~clk;

    neuron_lanes #(
        .IN_SIZE(IN_A), .LANES(LN), .WIDTH_IN(8), .WIDTH(8),
        .BIAS_WIDTH(8), .WIDTH_OUT(WO)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .weight(weight), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .busy(busy_a)
    );

    neuron_lanes dut_b (
        .clk(clk), .reset(reset), .start(start_b), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .weight(weight), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .busy(busy_b)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model for dut_a ----------------
    int     m_phase = 0;   // 0 idle, 1 taking beats, 2 reducing, 3 presenting
    int     m_taken = 0;
    int     m_wait  = 0;
    int     m_bias  = 0;
    int     m_e     = 0;
    longint m_out   = 0;
    int     m_x [IN_A];
    int     m_w [IN_A];

    function automatic longint wrapw(input longint v, input int w);
        longint m, r;
        m = longint'(1) << w;
        r = v & (m - 1);
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    function automatic longint expected_result();
        longint lane, tot;
        tot = m_bias;
        for (int k = 0; k < LN; k++) begin
            lane = 0;
            for (int e = k; e < IN_A; e += LN) lane += longint'(m_x[e]) * m_w[e];
            tot += wrapw(lane, WO);
        end
`ifdef NEURON_LANES_RELU_SAT_EN
        if (tot < 0) return 0;
        if (tot > (longint'(1) << (WO - 1)) - 1) return (longint'(1) << (WO - 1)) - 1;
        return tot;
`else
        return wrapw(tot, WO);
`endif
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_phase = 0;
            m_taken = 0;
            m_wait  = 0;
            m_out   = 0;
        end else begin
            case (m_phase)
                0: if (start_a) begin
                    m_bias  = int'($signed(bias));
                    m_taken = 0;
                    m_phase = 1;
                end
                1: if (in_valid) begin
                    for (int k = 0; k < LN; k++) begin
                        m_e = m_taken * LN + k;
                        if (m_e < IN_A) begin
                            m_x[m_e] = int'($signed(in_data[k*8 +: 8]));
                            m_w[m_e] = int'($signed(weight[k*8 +: 8]));
                        end
                    end
                    m_taken++;
                    if (m_taken == BEATS_A) begin
                        m_phase = 2;
                        m_wait  = 1;
                    end
                end
                2: if (m_wait > 0) m_wait--;
                   else begin
                       m_out   = expected_result();
                       m_phase = 3;
                   end
                3: if (out_ready) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    // Cycle-by-cycle comparison of dut_a against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready",  longint'(in_ready_a),  longint'(m_phase == 1));
            chk("m_busy",      longint'(busy_a),      longint'(m_phase != 0));
            chk("m_out_valid", longint'(out_valid_a), longint'(m_phase == 3));
            chk("m_out_data",  longint'($signed(out_data_a)), m_out);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_vec(input int x0, x1, x2, x3, x4, x5,
                           input int w0, w1, w2, w3, w4, w5);
        tx[0] = x0; tx[1] = x1; tx[2] = x2; tx[3] = x3; tx[4] = x4; tx[5] = x5;
        tw[0] = w0; tw[1] = w1; tw[2] = w2; tw[3] = w3; tw[4] = w4; tw[5] = w5;
    endtask

    task automatic run_a(input int b, input int gap, input int hold, input bit noise,
                         input int abort_at, output longint res, output int lat);
        bit rdy;
        int to, nh;
        logic [31:0] d, wv;
        res = 0;
        lat = -1;
        d = '0;
        wv = '0;
        bias = 8'(b);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        bias = 8'($urandom);
        for (int bt = 0; bt < BEATS_A; bt++) begin
            int ng;
            ng = (gap >= 0) ? gap : int'($urandom_range(2));
            for (int g = 0; g < ng; g++) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                weight   = $urandom;
                start_a  = noise;
                @(negedge clk);
            end
            start_a = 1'b0;
            for (int k = 0; k < LN; k++) begin
                int e;
                e = bt * LN + k;
                if (e < IN_A) begin
                    d[k*8 +: 8]  = 8'(tx[e]);
                    wv[k*8 +: 8] = 8'(tw[e]);
                end else if (junk_rand) begin
                    d[k*8 +: 8]  = 8'($urandom);
                    wv[k*8 +: 8] = 8'($urandom);
                end else begin
                    d[k*8 +: 8]  = 8'd99;
                    wv[k*8 +: 8] = 8'd7;
                end
            end
            in_data  = d;
            weight   = wv;
            in_valid = 1'b1;
            to = 0;
            do begin
                rdy = in_ready_a;
                @(negedge clk);
                to++;
            end while (!rdy && to < 20);
            if (!rdy) begin
                chk("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            if (bt == abort_at) begin
                in_valid = 1'b0;
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                chk("abort_busy",     longint'(busy_a), 0);
                chk("abort_valid",    longint'(out_valid_a), 0);
                chk("abort_data",     longint'($signed(out_data_a)), 0);
                chk("abort_in_ready", longint'(in_ready_a), 0);
                return;
            end
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        weight   = $urandom;
        lat = 0;
        while (!out_valid_a && lat < 20) begin
            chk("in_ready_reduce", longint'(in_ready_a), 0);
            @(negedge clk);
            lat++;
        end
        if (!out_valid_a) begin
            chk("out_valid_timeout", 0, 1);
            return;
        end
        res = $signed(out_data_a);
        nh = (hold >= 0) ? hold : int'($urandom_range(3));
        for (int h = 0; h < nh; h++) begin
            out_ready = 1'b0;
            start_a   = noise;
            @(negedge clk);
            chk("hold_valid",    longint'(out_valid_a), 1);
            chk("hold_in_ready", longint'(in_ready_a), 0);
        end
        out_ready = 1'b1;
        start_a   = noise;
        @(negedge clk);
        out_ready = 1'b0;
        start_a   = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        longint res;
        int     lat, cnt, to;
        bit     rdy;
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; bias = '0;
        in_valid = 1'b0; in_data = '0; weight = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", longint'(in_ready_a), 0);
        chk("rst_out_valid", longint'(out_valid_a), 0);
        chk("rst_out_data", longint'($signed(out_data_a)), 0);
        chk("rst_busy", longint'(busy_a), 0);
        chk("rst_busy_b", longint'(busy_b), 0);
        chk_en = 1'b1;
        reset = 1'b1;
        @(negedge clk);

        // Partial last beat: masked lanes carry 99s that must be ignored
        set_vec(1, 2, 3, 4, 5, 6, 1, 1, 1, 1, 2, -1);
        run_a(3, 0, 0, 1'b0, -1, res, lat);
        chk("t1_result", res, 17);
        chk("t1_latency", lat, 2);

        // Input gaps and output back-pressure
        run_a(3, 3, 5, 1'b0, -1, res, lat);
        chk("t3_result", res, 17);

        // Reset after the first beat, then a fresh run
        run_a(3, 0, 0, 1'b0, 0, res, lat);
        run_a(3, 0, 0, 1'b0, -1, res, lat);
        chk("t4_result", res, 17);

        // start pulses in ACCUM and OUTPUT, and with the output handshake
        run_a(3, 1, 2, 1'b1, -1, res, lat);
        chk("t5_result", res, 17);
        chk("t5_busy", longint'(busy_a), 0);
        chk("t5_in_ready", longint'(in_ready_a), 0);
        @(negedge clk);
        chk("t5_still_idle", longint'(busy_a), 0);

        // Negative sum: -60 + 10 = -50
        set_vec(10, 0, 0, 0, 0, 0, -6, 0, 0, 0, 0, 0);
        run_a(10, 0, 0, 1'b0, -1, res, lat);
        chk("t6_negative", res, EXP_NEG);

        // Sum 40000 in a 16-bit result
        set_vec(127, 79, 0, 0, 127, 0, 127, 98, 0, 0, 127, 0);
        run_a(0, 0, 1, 1'b0, -1, res, lat);
        chk("t7_big", res, EXP_BIG);

        // Full-size default instance: 196 * (127 * -128) - 128
        bias = 8'h80;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        in_data = 32'h7f7f7f7f;
        weight  = 32'h80808080;
        in_valid = 1'b1;
        cnt = 0;
        to = 0;
        while (cnt < BEATS_B && to < 200) begin
            rdy = in_ready_b;
            @(negedge clk);
            if (rdy) cnt++;
            to++;
        end
        in_valid = 1'b0;
        chk("b_beats", cnt, BEATS_B);
        to = 0;
        while (!out_valid_b && to < 20) begin
            @(negedge clk);
            to++;
        end
        chk("b_latency", to, 2);
        chk("b_result", longint'($signed(out_data_b)), EXP_B);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("b_idle", longint'(busy_b), 0);

        // Randomized runs against the model
        junk_rand = 1'b1;
        for (int r = 0; r < 40; r++) begin
            for (int e = 0; e < IN_A; e++) begin
                tx[e] = int'($urandom_range(255)) - 128;
                tw[e] = int'($urandom_range(255)) - 128;
            end
            run_a(int'($urandom_range(255)) - 128, -1, -1, 1'($urandom_range(1)),
                  ($urandom_range(7) == 0) ? 0 : -1, res, lat);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected completion before time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/neuron_lanes.md
Name: neuron_lanes

Overview:
- Parametrised successor to the single-MAC neuron.
- Computes one fully-connected neuron output, out = sum(x[i]*w[i]) + bias, using LANES parallel signed MACs, so the dot product takes ceil(IN_SIZE/LANES) beats instead of IN_SIZE cycles.
- Inputs and weights are streamed with a valid/ready handshake; the result leaves through a valid/ready output port.
- Sits between the layer controller / weight ROM reader and the layer output buffer.

Parameters:
IN_SIZE, 196, number of input elements per neuron (>=1)
LANES, 4, parallel multiply lanes per beat (>=1)
WIDTH_IN, 8, signed input element width
WIDTH, 8, signed weight width
BIAS_WIDTH, 8, signed bias width
WIDTH_OUT, 32, accumulator/output width (>= WIDTH_IN+WIDTH)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  begin a neuron computation; sampled only in IDLE
bias  in  BIAS_WIDTH  signed bias; sampled on the cycle start is accepted
in_valid  in  1  in_data/weight beat valid
in_ready  out  1  block accepts a beat
in_data  in  LANES*WIDTH_IN  lane k at bits [(k+1)*WIDTH_IN-1 -: WIDTH_IN], signed
weight  in  LANES*WIDTH  lane k at bits [(k+1)*WIDTH-1 -: WIDTH], signed
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts result
out_data  out  WIDTH_OUT  signed neuron result
busy  out  1  high in every state except IDLE

Behaviour:
- BEATS = ceil(IN_SIZE/LANES). A beat counter (0..BEATS-1) counts accepted beats (in_valid & in_ready).
- Reset (reset==0 at a clock edge), including mid-operation:
  - state goes to IDLE; lane accumulators, beat counter and bias register clear to 0;
  - out_valid=0, out_data=0, in_ready=0, busy=0.
- States:
  - IDLE: in_ready=0. start=1 -> latch bias, clear accumulators and beat counter -> ACCUM.
  - ACCUM: in_ready=1. On each handshake, every lane k does acc[k] += x[k]*w[k] as a signed product, sign-extended to WIDTH_OUT.
    - Lane k of the beat with index b is element b*LANES+k. Any element index >= IN_SIZE (partial last beat) contributes 0 regardless of the data on the bus.
    - Handshake on beat BEATS-1 -> REDUCE. in_valid=0 stalls with no state change.
  - REDUCE: one cycle, in_ready=0. out_data <= sum of all acc[k] + sign-extended bias, registered; then -> OUTPUT.
  - OUTPUT: out_valid=1 and out_data held stable until out_ready=1. That handshake -> IDLE, out_valid=0, out_data keeps its last value.
- Arithmetic: two's complement, wrapping modulo 2^WIDTH_OUT, no saturation (unless the optional feature is enabled).
- Latency:
  - start accepted at edge T -> in_ready=1 from T+1.
  - Last beat accepted at edge L -> out_valid=1 after edge L+2 (one REDUCE cycle).
  - With gap-free input: BEATS+2 cycles from start to out_valid.
- start is ignored outside IDLE. start and the out_ready handshake in the same cycle: the block goes to IDLE only; start must be reasserted.
- in_valid is ignored when in_ready=0.
- The adder tree may be split or pipelined internally only if REDUCE latency stays exactly 1 cycle as seen at the ports.
- IN_SIZE < LANES: BEATS=1, and the unused lanes are masked.

Optional Feature:
- Macro: NEURON_LANES_RELU_SAT_EN.
- Defined:
  - The REDUCE sum is computed in WIDTH_OUT+$clog2(LANES+1)+1 bits.
  - Result <0 is replaced by 0 (ReLU).
  - Result > 2^(WIDTH_OUT-1)-1 is clamped to that value.
  - Latency unchanged.
- Undefined: raw wrapped sum, no activation, and no extra width logic is synthesised.

Test Plan:
- IN_SIZE=6, LANES=4, bias=3. Beat0 x={1,2,3,4}, w={1,1,1,1}; beat1 x={5,6,99,99}, w={2,-1,7,7}. Required: out_data=17 (10+4+3; the masked lanes ignore the 99s); out_valid exactly 2 cycles after beat1 is accepted.
- Default params, every x=127 and w=-128, bias=-128. Required: out_data = 196*(-16256) - 128 = -3186304.
- Same sum as the first test, but in_valid deasserted for 3 cycles between beats and out_ready held low for 5 cycles. Required: result unchanged; out_data stable during the stall; in_ready=0 in REDUCE and OUTPUT.
- reset driven low for 1 cycle after the first beat. Required next cycle: IDLE, busy=0, out_valid=0, out_data=0. A fresh run then gives the correct result with no residue from the aborted run.
- start pulsed during ACCUM and OUTPUT: no effect. start and out_ready together in OUTPUT: IDLE, no new run started.
- With NEURON_LANES_RELU_SAT_EN:
  - inputs giving sum -50 -> out_data=0;
  - WIDTH_OUT=16, sum 40000 -> out_data=32767;
  - without the macro, sum 40000 -> out_data=-25536.
